// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
// Holds the FSM state enum, BCD digit limits and a prescaler width helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVF   = 2'd3
  } sw_state_e;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic int psc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single decimal digit counter, 0..9, wrapping on increment at 9.
// Ports: clk, rst/clr (sync zero), en (increment), q (digit), at_max (q==9).
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [BCD_W-1:0] q,
  output logic             at_max
);

  assign at_max = (q == BCD_MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= at_max ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear stopwatch: prescaler, FSM, BCD carry chain, lap display.
// Ports: clk, rst, start/stop/clear/lap pulses -> digits, display, running, overflow, tick.
module bcd_stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [4*NUM_DIGITS-1:0] display,
  output logic                    running,
  output logic                    overflow,
  output logic                    tick
);

  localparam int            PW       = psc_width(TICK_DIV);
  localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);

  sw_state_e state, state_nxt;

  logic [PW-1:0]           psc, psc_nxt;
  logic                    lap_hold, lap_nxt;
  logic [4*NUM_DIGITS-1:0] disp_q;
  logic [NUM_DIGITS-1:0]   at_max;
  logic [NUM_DIGITS-1:0]   carry;
  logic                    all_nine;

  assign all_nine = &at_max;
  assign tick     = (state == RUN) && (psc == PSC_LAST)
                  && !stop && !clear && !rst;
  assign running  = (state == RUN);
  assign overflow = (state == OVF);
  assign display  = disp_q;

  // A tick at all nines freezes the count instead of wrapping.
  assign carry[0] = tick & ~all_nine;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    if (k > 0) begin : g_c
      assign carry[k] = carry[k-1] & at_max[k-1];
    end
    bcd_digit u_dig (
      .clk    (clk),
      .rst    (rst),
      .clr    (clear),
      .en     (carry[k]),
      .q      (digits[k*BCD_W +: BCD_W]),
      .at_max (at_max[k])
    );
  end

  always_comb begin
    state_nxt = state;
    psc_nxt   = psc;
    unique case (state)
      IDLE: begin
        psc_nxt = '0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        // stop freezes the prescaler so resume keeps the fraction
        if (stop) begin
          state_nxt = PAUSE;
        end else if (tick) begin
          psc_nxt = '0;
          if (all_nine) state_nxt = OVF;
        end else begin
          psc_nxt = psc + PW'(1);
        end
      end
      PAUSE: begin
        if (start) state_nxt = RUN;
      end
      OVF: begin
        psc_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        psc_nxt   = '0;
      end
    endcase
    if (clear) begin
      state_nxt = IDLE;
      psc_nxt   = '0;
    end
  end

  always_comb begin
    lap_nxt = lap_hold;
    if (lap && (state == RUN || state == PAUSE))
      lap_nxt = ~lap_hold;
    if (clear)
      lap_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      psc      <= '0;
      lap_hold <= 1'b0;
      disp_q   <= '0;
    end else begin
      state    <= state_nxt;
      psc      <= psc_nxt;
      lap_hold <= lap_nxt;
      // the edge that sets lap_hold still loads, which is the snapshot
      if (clear)
        disp_q <= '0;
      else if (!lap_hold)
        disp_q <= digits;
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Self-checking bench for bcd_stopwatch_ctrl (NUM_DIGITS=2, TICK_DIV=3).
// Integer-count reference model; directed scenarios plus random pulses.
module tb_bcd_stopwatch_ctrl;

  localparam int ND   = 2;
  localparam int TD   = 3;
  localparam int W    = 4 * ND;
  localparam int MAXC = 99;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_OVF   = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         clear = 1'b0;
  logic         lap = 1'b0;
  logic [W-1:0] digits;
  logic [W-1:0] display;
  logic         running;
  logic         overflow;
  logic         tick;

  bcd_stopwatch_ctrl #(
    .NUM_DIGITS (ND),
    .TICK_DIV   (TD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .lap      (lap),
    .digits   (digits),
    .display  (display),
    .running  (running),
    .overflow (overflow),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int m_st   = S_IDLE;
  int m_psc  = 0;
  int m_cnt  = 0;
  int m_disp = 0;
  bit m_lap  = 0;
  bit exp_tick;
  bit got_tick;

  function automatic logic [W-1:0] bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic step(input bit s, input bit p, input bit c,
                      input bit l, input bit r);
    start = s; stop = p; clear = c; lap = l; rst = r;
    @(negedge clk);
    got_tick = tick;
    exp_tick = (m_st == S_RUN) && (m_psc == TD - 1) && !p && !c && !r;
    @(posedge clk);
    if (r || c) begin
      m_st = S_IDLE; m_psc = 0; m_cnt = 0; m_disp = 0; m_lap = 0;
    end else begin
      if (!m_lap) m_disp = m_cnt;
      if (l && (m_st == S_RUN || m_st == S_PAUSE)) m_lap = !m_lap;
      case (m_st)
        S_IDLE:  if (s) m_st = S_RUN;
        S_RUN: begin
          if (p) m_st = S_PAUSE;
          else if (exp_tick) begin
            m_psc = 0;
            if (m_cnt == MAXC) m_st = S_OVF;
            else m_cnt++;
          end else m_psc++;
        end
        S_PAUSE: if (s) m_st = S_RUN;
        default: ;
      endcase
    end
    #1;
    start = 0; stop = 0; clear = 0; lap = 0; rst = 0;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    n_cmp++;
    if (digits !== '0) begin
      n_err++; $display("FAIL reset_digits: got %h want 00", digits);
    end
    n_cmp++;
    if (display !== '0) begin
      n_err++; $display("FAIL reset_display: got %h want 00", display);
    end
    n_cmp++;
    if ({running, overflow} !== 2'b00) begin
      n_err++; $display("FAIL reset_flags: got %b want 00", {running, overflow});
    end
  endtask

  task automatic test_count_carry();
    step(1, 0, 0, 0, 0);
    n_cmp++;
    if (running !== 1'b1) begin
      n_err++; $display("FAIL start_running: got %b want 1", running);
    end
    for (int i = 0; i < 10 * TD; i++) begin
      step(0, 0, 0, 0, 0);
      n_cmp++;
      if (got_tick !== exp_tick) begin
        n_err++; $display("FAIL count_tick cyc%0d: got %b want %b", i, got_tick, exp_tick);
      end
      n_cmp++;
      if (digits !== bcd(m_cnt)) begin
        n_err++; $display("FAIL count_digits cyc%0d: got %h want %h", i, digits, bcd(m_cnt));
      end
      if (i == 9 * TD - 1) begin
        n_cmp++;
        if (digits !== 8'h09) begin
          n_err++; $display("FAIL count_nine: got %h want 09", digits);
        end
      end
    end
    n_cmp++;
    if (digits !== 8'h10) begin
      n_err++; $display("FAIL count_carry: got %h want 10", digits);
    end
  endtask

  task automatic test_pause_fraction();
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0);
      n_cmp++;
      if (digits !== 8'h00 || running !== 1'b0 || got_tick !== 1'b0) begin
        n_err++;
        $display("FAIL pause_hold cyc%0d: got d=%h r=%b t=%b want 00 0 0",
                 i, digits, running, got_tick);
      end
    end
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    n_cmp++;
    if (got_tick !== 1'b0) begin
      n_err++; $display("FAIL resume_first: got tick %b want 0", got_tick);
    end
    step(0, 0, 0, 0, 0);
    n_cmp++;
    if (got_tick !== 1'b1 || digits !== 8'h01) begin
      n_err++; $display("FAIL resume_fraction: got t=%b d=%h want 1 01", got_tick, digits);
    end
  endtask

  task automatic test_stop_on_tick();
    for (int i = 0; i < 10 && m_psc != TD - 1; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    n_cmp++;
    if (got_tick !== 1'b0 || running !== 1'b0 || digits !== 8'h01) begin
      n_err++;
      $display("FAIL stop_on_tick: got t=%b r=%b d=%h want 0 0 01",
               got_tick, running, digits);
    end
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    n_cmp++;
    if (got_tick !== 1'b1 || digits !== 8'h02) begin
      n_err++; $display("FAIL stop_psc_held: got t=%b d=%h want 1 02", got_tick, digits);
    end
  endtask

  task automatic test_overflow();
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 400 && m_st != S_OVF; i++) begin
      step(0, 0, 0, 0, 0);
      n_cmp++;
      if (digits !== bcd(m_cnt)) begin
        n_err++; $display("FAIL ovf_run cyc%0d: got %h want %h", i, digits, bcd(m_cnt));
      end
    end
    n_cmp++;
    if (overflow !== 1'b1 || running !== 1'b0 || digits !== 8'h99) begin
      n_err++;
      $display("FAIL ovf_enter: got o=%b r=%b d=%h want 1 0 99", overflow, running, digits);
    end
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    n_cmp++;
    if (overflow !== 1'b1 || running !== 1'b0 || digits !== 8'h99) begin
      n_err++;
      $display("FAIL ovf_start_ignored: got o=%b r=%b d=%h want 1 0 99",
               overflow, running, digits);
    end
    step(0, 0, 1, 0, 0);
    n_cmp++;
    if (overflow !== 1'b0 || running !== 1'b0 || digits !== 8'h00) begin
      n_err++;
      $display("FAIL ovf_clear: got o=%b r=%b d=%h want 0 0 00", overflow, running, digits);
    end
  endtask

  task automatic test_lap();
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 200 && m_cnt != 23; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0, 0, 0);
      n_cmp++;
      if (display !== 8'h23 || digits !== bcd(m_cnt)) begin
        n_err++;
        $display("FAIL lap_freeze cyc%0d: got disp=%h d=%h want 23 %h",
                 i, display, digits, bcd(m_cnt));
      end
    end
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0);
      n_cmp++;
      if (display !== bcd(m_disp)) begin
        n_err++; $display("FAIL lap_release cyc%0d: got %h want %h", i, display, bcd(m_disp));
      end
    end
  endtask

  task automatic test_clear_priority();
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    n_cmp++;
    if (running !== 1'b0 || digits !== 8'h00 || display !== 8'h00) begin
      n_err++;
      $display("FAIL clear_wins: got r=%b d=%h disp=%h want 0 00 00",
               running, digits, display);
    end
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
    n_cmp++;
    if (display !== bcd(m_disp) || running !== 1'b1) begin
      n_err++; $display("FAIL clear_lap_off: got %h want %h", display, bcd(m_disp));
    end
    step(0, 0, 0, 0, 1);
    n_cmp++;
    if ({digits, display, running, overflow} !== '0) begin
      n_err++;
      $display("FAIL rst_mid: got d=%h disp=%h r=%b o=%b want all 0",
               digits, display, running, overflow);
    end
  endtask

  task automatic test_random();
    bit s, p, c, l, r;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom % 1000) == 0;
      c = ($urandom % 250) == 0;
      s = ($urandom % 8) == 0;
      p = ($urandom % 40) == 0;
      l = !s && !p && (($urandom % 25) == 0);
      step(s, p, c, l, r);
      n_cmp++;
      if (got_tick !== exp_tick || digits !== bcd(m_cnt) ||
          display !== bcd(m_disp) || running !== (m_st == S_RUN) ||
          overflow !== (m_st == S_OVF)) begin
        n_err++;
        $display("FAIL random cyc%0d: got t=%b d=%h disp=%h r=%b o=%b want %b %h %h %b %b",
                 i, got_tick, digits, display, running, overflow,
                 exp_tick, bcd(m_cnt), bcd(m_disp), m_st == S_RUN, m_st == S_OVF);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_carry();
    test_pause_fraction();
    test_stop_on_tick();
    test_overflow();
    test_lap();
    test_clear_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
